// File: rtl/collision_pkg.sv
// Shared types for the player collision checker: FSM states and the
// encoding of the four sprite corners probed against the safe-zone map.
package collision_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    QUERY,
    SAMPLE,
    DONE
  } state_t;

  typedef logic [1:0] corner_t;

  localparam corner_t CORNER_TL = 2'd0;
  localparam corner_t CORNER_TR = 2'd1;
  localparam corner_t CORNER_BL = 2'd2;
  localparam corner_t CORNER_BR = 2'd3;

  // Right-hand corners sit PLAYER_SIZE-1 pixels to the right of the anchor.
  function automatic logic corner_has_x_offset(input corner_t c);
    return (c == CORNER_TR) || (c == CORNER_BR);
  endfunction

  // Bottom corners sit PLAYER_SIZE-1 pixels below the anchor.
  function automatic logic corner_has_y_offset(input corner_t c);
    return (c == CORNER_BL) || (c == CORNER_BR);
  endfunction

endpackage

// File: rtl/player_zone_checker.sv
// Checks the four corners of the player sprite against the safe-zone map,
// one corner per two-cycle query/sample slot, and reports a per-corner
// unsafe mask. Corners that land off screen are flagged without consulting
// the map. A map regeneration (i_zone_rdy low) mid-check restarts the walk.
module player_zone_checker
  import collision_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 400,
  parameter int SCREEN_HEIGHT = 600,
  parameter int BLOCK_SIZE    = 10,
  parameter int PLAYER_SIZE   = 20
) (
  input  logic                             clk,
  input  logic                             arst,
  input  logic                             i_start,
  input  logic [$clog2(SCREEN_WIDTH)-1:0]  i_px,
  input  logic [$clog2(SCREEN_HEIGHT)-1:0] i_py,
  input  logic                             i_zone_rdy,
  output logic [$clog2(SCREEN_WIDTH)-1:0]  o_query_x,
  output logic [$clog2(SCREEN_HEIGHT)-1:0] o_query_y,
  input  logic                             i_is_safe,
  output logic                             o_busy,
  output logic                             o_done,
  output logic [3:0]                       o_unsafe_mask,
  output logic                             o_all_safe
);

  localparam int XW = $clog2(SCREEN_WIDTH);
  localparam int YW = $clog2(SCREEN_HEIGHT);
  localparam int XS = XW + 1;
  localparam int YS = YW + 1;

  // Corner sums carry one extra bit so a sprite hanging off the right or
  // bottom edge is detected instead of wrapping back onto the screen.
  localparam logic [XW:0] X_LIMIT = XS'(SCREEN_WIDTH);
  localparam logic [YW:0] Y_LIMIT = YS'(SCREEN_HEIGHT);
  localparam logic [XW:0] X_OFF   = XS'(PLAYER_SIZE - 1);
  localparam logic [YW:0] Y_OFF   = YS'(PLAYER_SIZE - 1);

  state_t        state;
  state_t        next_state;
  corner_t       corner;
  logic [XW-1:0] cap_x;
  logic [YW-1:0] cap_y;
  logic [3:0]    work_mask;
  logic [XW:0]   corner_x;
  logic [YW:0]   corner_y;
  logic          corner_oob;

  // Address of the corner currently being probed, plus its off-screen flag.
  always_comb begin
    corner_x = {1'b0, cap_x};
    corner_y = {1'b0, cap_y};
    if (corner_has_x_offset(corner)) begin
      corner_x = corner_x + X_OFF;
    end
    if (corner_has_y_offset(corner)) begin
      corner_y = corner_y + Y_OFF;
    end
    corner_oob = (corner_x >= X_LIMIT) || (corner_y >= Y_LIMIT);
  end

  // State register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; losing the map in QUERY or SAMPLE parks us in WAIT_RDY.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (i_start) begin
          next_state = i_zone_rdy ? QUERY : WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (i_zone_rdy) begin
          next_state = QUERY;
        end
      end
      QUERY: begin
        next_state = i_zone_rdy ? SAMPLE : WAIT_RDY;
      end
      SAMPLE: begin
        if (!i_zone_rdy) begin
          next_state = WAIT_RDY;
        end else if (corner == CORNER_BR) begin
          next_state = DONE;
        end else begin
          next_state = QUERY;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Busy covers the whole check, including waiting for the map.
  always_comb begin
    o_busy = (state != IDLE);
  end

  // Datapath: position capture, corner walk, working mask and result outputs.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cap_x         <= '0;
      cap_y         <= '0;
      corner        <= CORNER_TL;
      work_mask     <= '0;
      o_query_x     <= '0;
      o_query_y     <= '0;
      o_done        <= 1'b0;
      o_unsafe_mask <= '0;
      o_all_safe    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            cap_x     <= i_px;
            cap_y     <= i_py;
            corner    <= CORNER_TL;
            work_mask <= '0;
          end
        end
        WAIT_RDY: begin
          corner    <= CORNER_TL;
          work_mask <= '0;
        end
        QUERY: begin
          if (i_zone_rdy) begin
            o_query_x <= corner_x[XW-1:0];
            o_query_y <= corner_y[YW-1:0];
          end else begin
            corner    <= CORNER_TL;
            work_mask <= '0;
          end
        end
        SAMPLE: begin
          if (i_zone_rdy) begin
            work_mask[corner] <= corner_oob | ~i_is_safe;
            corner            <= corner + 2'd1;
          end else begin
            corner    <= CORNER_TL;
            work_mask <= '0;
          end
        end
        DONE: begin
          o_unsafe_mask <= work_mask;
          o_all_safe    <= (work_mask == 4'b0000);
          o_done        <= 1'b1;
        end
        default: begin
          corner <= CORNER_TL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_zone_checker.sv
// Self-checking bench for player_zone_checker. The safe-zone map is a
// combinational cell array answering the DUT's queries; expected masks and
// query addresses are computed from sprite geometry with plain arithmetic.
module tb_player_zone_checker;

  localparam int SW = 400;
  localparam int SH = 600;
  localparam int BS = 10;
  localparam int PS = 20;
  localparam int XW = $clog2(SW);
  localparam int YW = $clog2(SH);
  localparam int CX = SW / BS;
  localparam int CY = SH / BS;

  logic          clk = 1'b0;
  logic          arst;
  logic          i_start;
  logic [XW-1:0] i_px;
  logic [YW-1:0] i_py;
  logic          i_zone_rdy;
  logic [XW-1:0] o_query_x;
  logic [YW-1:0] o_query_y;
  logic          i_is_safe;
  logic          o_busy;
  logic          o_done;
  logic [3:0]    o_unsafe_mask;
  logic          o_all_safe;

  int checks = 0;
  int fails  = 0;

  bit unsafe_cell [CX][CY];
  int obs_qx [4];
  int obs_qy [4];
  int obs_lat;
  bit obs_busy_ok;

  always #5 clk = ~clk;

  player_zone_checker #(
    .SCREEN_WIDTH (SW),
    .SCREEN_HEIGHT(SH),
    .BLOCK_SIZE   (BS),
    .PLAYER_SIZE  (PS)
  ) dut (
    .clk          (clk),
    .arst         (arst),
    .i_start      (i_start),
    .i_px         (i_px),
    .i_py         (i_py),
    .i_zone_rdy   (i_zone_rdy),
    .o_query_x    (o_query_x),
    .o_query_y    (o_query_y),
    .i_is_safe    (i_is_safe),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_unsafe_mask(o_unsafe_mask),
    .o_all_safe   (o_all_safe)
  );

  // Map model: answers for the queried pixel; off-screen queries claim safe.
  always_comb begin
    i_is_safe = 1'b1;
    if (int'(o_query_x) < SW && int'(o_query_y) < SH) begin
      i_is_safe = !unsafe_cell[int'(o_query_x) / BS][int'(o_query_y) / BS];
    end
  end

  function automatic int corner_x(input int px, input int c);
    return px + (((c % 2) == 1) ? PS - 1 : 0);
  endfunction

  function automatic int corner_y(input int py, input int c);
    return py + ((c >= 2) ? PS - 1 : 0);
  endfunction

  // A corner is unsafe if it is off screen or its map cell is unsafe.
  function automatic logic [3:0] model_mask(input int px, input int py);
    logic [3:0] m;
    m = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      int x;
      int y;
      x = corner_x(px, c);
      y = corner_y(py, c);
      if (x >= SW || y >= SH) begin
        m[c] = 1'b1;
      end else begin
        m[c] = unsafe_cell[x / BS][y / BS];
      end
    end
    return m;
  endfunction

  task automatic clear_map();
    for (int x = 0; x < CX; x++) begin
      for (int y = 0; y < CY; y++) begin
        unsafe_cell[x][y] = 1'b0;
      end
    end
  endtask

  // Issues one start pulse and records query addresses, busy and latency.
  task automatic run_check(input int px, input int py);
    @(negedge clk);
    i_px    = XW'(px);
    i_py    = YW'(py);
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start     = 1'b0;
    obs_lat     = -1;
    obs_busy_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if ((k % 2) == 1 && k <= 7) begin
        obs_qx[k / 2] = int'(o_query_x);
        obs_qy[k / 2] = int'(o_query_y);
      end
      if (o_done) begin
        obs_lat = k;
        break;
      end
      if (!o_busy) obs_busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    arst       = 1'b1;
    i_start    = 1'b0;
    i_px       = '0;
    i_py       = '0;
    i_zone_rdy = 1'b1;
    clear_map();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({o_busy, o_done, o_all_safe} !== 3'b000) begin
      fails++;
      $display("[TB] FAIL reset_flags: busy/done/all_safe got %b expected 000", {o_busy, o_done, o_all_safe});
    end
    checks++;
    if (o_unsafe_mask !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL reset_mask: got %b expected 0000", o_unsafe_mask);
    end
    checks++;
    if (o_query_x !== '0 || o_query_y !== '0) begin
      fails++;
      $display("[TB] FAIL reset_query: got (%0d,%0d) expected (0,0)", o_query_x, o_query_y);
    end
    @(negedge clk);
    arst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (o_busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_idle_busy: got %b expected 0", o_busy);
    end
  endtask

  task automatic test_all_safe();
    clear_map();
    run_check(100, 100);
    checks++;
    if (obs_lat !== 9) begin
      fails++;
      $display("[TB] FAIL all_safe_latency: got %0d expected 9", obs_lat);
    end
    checks++;
    if (obs_busy_ok !== 1'b1) begin
      fails++;
      $display("[TB] FAIL all_safe_busy: busy dropped during check");
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (obs_qx[c] !== corner_x(100, c) || obs_qy[c] !== corner_y(100, c)) begin
        fails++;
        $display("[TB] FAIL all_safe_query%0d: got (%0d,%0d) expected (%0d,%0d)",
                 c, obs_qx[c], obs_qy[c], corner_x(100, c), corner_y(100, c));
      end
    end
    checks++;
    if (o_unsafe_mask !== 4'b0000 || o_all_safe !== 1'b1) begin
      fails++;
      $display("[TB] FAIL all_safe_result: got mask %b all_safe %b expected 0000/1", o_unsafe_mask, o_all_safe);
    end
    @(posedge clk);
    #1;
    checks++;
    if (o_done !== 1'b0 || o_unsafe_mask !== 4'b0000 || o_all_safe !== 1'b1) begin
      fails++;
      $display("[TB] FAIL done_pulse_width: got done %b mask %b all_safe %b expected 0/0000/1",
               o_done, o_unsafe_mask, o_all_safe);
    end
  endtask

  task automatic test_br_unsafe();
    clear_map();
    unsafe_cell[11][11] = 1'b1;
    run_check(100, 100);
    checks++;
    if (obs_lat !== 9 || o_unsafe_mask !== 4'b1000 || o_all_safe !== 1'b0) begin
      fails++;
      $display("[TB] FAIL br_unsafe: got lat %0d mask %b all_safe %b expected 9/1000/0",
               obs_lat, o_unsafe_mask, o_all_safe);
    end
  endtask

  task automatic test_right_edge();
    clear_map();
    run_check(390, 100);
    checks++;
    if (obs_qx[1] !== 409 || obs_qx[3] !== 409) begin
      fails++;
      $display("[TB] FAIL right_edge_query: got TR x %0d BR x %0d expected 409", obs_qx[1], obs_qx[3]);
    end
    checks++;
    if (obs_lat !== 9 || o_unsafe_mask !== 4'b1010 || o_all_safe !== 1'b0) begin
      fails++;
      $display("[TB] FAIL right_edge: got lat %0d mask %b all_safe %b expected 9/1010/0",
               obs_lat, o_unsafe_mask, o_all_safe);
    end
  endtask

  task automatic test_wait_rdy();
    bit ok;
    int lat;
    clear_map();
    unsafe_cell[10][10] = 1'b1;
    @(negedge clk);
    i_zone_rdy = 1'b0;
    i_px       = XW'(100);
    i_py       = YW'(100);
    i_start    = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    ok      = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (o_busy !== 1'b1 || o_done !== 1'b0) ok = 1'b0;
    end
    @(negedge clk);
    i_zone_rdy = 1'b1;
    @(posedge clk);
    #1;
    if (o_busy !== 1'b1) ok = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (o_done) begin
        lat = k;
        break;
      end
      if (o_busy !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (ok !== 1'b1) begin
      fails++;
      $display("[TB] FAIL wait_rdy_busy: busy low or early done while waiting");
    end
    checks++;
    if (lat !== 9 || o_unsafe_mask !== 4'b0001) begin
      fails++;
      $display("[TB] FAIL wait_rdy_result: got lat %0d mask %b expected 9/0001", lat, o_unsafe_mask);
    end
  endtask

  task automatic test_abort();
    int lat;
    int dones;
    int qx [4];
    int qy [4];
    clear_map();
    unsafe_cell[10][11] = 1'b1;
    unsafe_cell[20][30] = 1'b1;
    @(negedge clk);
    i_px    = XW'(100);
    i_py    = YW'(100);
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    lat     = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k >= 9 && k <= 15 && (k % 2) == 1) begin
        qx[(k - 9) / 2] = int'(o_query_x);
        qy[(k - 9) / 2] = int'(o_query_y);
      end
      if (o_done) begin
        lat = k;
        break;
      end
      if (k == 4) i_zone_rdy = 1'b0;
      if (k == 7) i_zone_rdy = 1'b1;
      if (k == 9) begin
        i_px    = XW'(200);
        i_py    = YW'(300);
        i_start = 1'b1;
      end
      if (k == 10) i_start = 1'b0;
    end
    checks++;
    if (lat !== 17) begin
      fails++;
      $display("[TB] FAIL abort_latency: got %0d expected 17", lat);
    end
    checks++;
    if (o_unsafe_mask !== model_mask(100, 100) || o_unsafe_mask !== 4'b0100) begin
      fails++;
      $display("[TB] FAIL abort_mask: got %b expected 0100", o_unsafe_mask);
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (qx[c] !== corner_x(100, c) || qy[c] !== corner_y(100, c)) begin
        fails++;
        $display("[TB] FAIL abort_restart_query%0d: got (%0d,%0d) expected (%0d,%0d)",
                 c, qx[c], qy[c], corner_x(100, c), corner_y(100, c));
      end
    end
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (o_done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      fails++;
      $display("[TB] FAIL abort_second_start: got %0d extra done pulses expected 0", dones);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    int busies;
    clear_map();
    @(negedge clk);
    i_px    = XW'(100);
    i_py    = YW'(100);
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    arst = 1'b1;
    #1;
    checks++;
    if ({o_busy, o_done, o_all_safe} !== 3'b000 || o_unsafe_mask !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL reset_mid_outputs: got busy %b done %b all_safe %b mask %b expected all 0",
               o_busy, o_done, o_all_safe, o_unsafe_mask);
    end
    checks++;
    if (o_query_x !== '0 || o_query_y !== '0) begin
      fails++;
      $display("[TB] FAIL reset_mid_query: got (%0d,%0d) expected (0,0)", o_query_x, o_query_y);
    end
    @(negedge clk);
    arst   = 1'b0;
    dones  = 0;
    busies = 0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      #1;
      if (o_done) dones++;
      if (o_busy) busies++;
    end
    checks++;
    if (dones !== 0 || busies !== 0) begin
      fails++;
      $display("[TB] FAIL reset_mid_discard: got %0d done and %0d busy cycles expected 0/0", dones, busies);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      int px;
      int py;
      logic [3:0] exp_mask;
      for (int x = 0; x < CX; x++) begin
        for (int y = 0; y < CY; y++) begin
          unsafe_cell[x][y] = ($urandom_range(0, 3) == 0);
        end
      end
      px = int'($urandom_range(0, 450));
      py = int'($urandom_range(0, 640));
      exp_mask = model_mask(px, py);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      run_check(px, py);
      checks++;
      if (obs_lat !== 9) begin
        fails++;
        $display("[TB] FAIL random%0d_latency: got %0d expected 9", it, obs_lat);
      end
      checks++;
      if (o_unsafe_mask !== exp_mask || o_all_safe !== (exp_mask == 4'b0000)) begin
        fails++;
        $display("[TB] FAIL random%0d_mask: at (%0d,%0d) got mask %b all_safe %b expected %b/%b",
                 it, px, py, o_unsafe_mask, o_all_safe, exp_mask, (exp_mask == 4'b0000));
      end
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (obs_qx[c] !== (corner_x(px, c) % (1 << XW)) || obs_qy[c] !== (corner_y(py, c) % (1 << YW))) begin
          fails++;
          $display("[TB] FAIL random%0d_query%0d: got (%0d,%0d) expected (%0d,%0d)", it, c,
                   obs_qx[c], obs_qy[c], corner_x(px, c) % (1 << XW), corner_y(py, c) % (1 << YW));
        end
      end
    end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_all_safe();
    test_br_unsafe();
    test_right_edge();
    test_wait_rdy();
    test_abort();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
